// File: rtl/shrv32_pkg.sv
// rtl/shrv32_pkg.sv - RV32I opcode constants and op-class encoding
// Contents:
//   OPC_*       7-bit major opcodes of the nine supported classes
//   opclass_t   4-bit op-class code driven on OPCLASS
//   opclass_of  maps a major opcode to its class, OC_NOP for unknown opcodes
package shrv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    OC_NOP    = 4'd0,
    OC_LUI    = 4'd1,
    OC_AUIPC  = 4'd2,
    OC_JAL    = 4'd3,
    OC_JALR   = 4'd4,
    OC_BRANCH = 4'd5,
    OC_LOAD   = 4'd6,
    OC_STORE  = 4'd7,
    OC_OPIMM  = 4'd8,
    OC_OP     = 4'd9
  } opclass_t;

  function automatic opclass_t opclass_of(input logic [6:0] opc);
    opclass_t c;
    case (opc)
      OPC_LUI:    c = OC_LUI;
      OPC_AUIPC:  c = OC_AUIPC;
      OPC_JAL:    c = OC_JAL;
      OPC_JALR:   c = OC_JALR;
      OPC_BRANCH: c = OC_BRANCH;
      OPC_LOAD:   c = OC_LOAD;
      OPC_STORE:  c = OC_STORE;
      OPC_OPIMM:  c = OC_OPIMM;
      OPC_OP:     c = OC_OP;
      default:    c = OC_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I immediate generator
// Ports:
//   instr  in  32  instruction word
//   imm    out 32  sign-extended immediate for the instruction's format
//                  (zero for R-type and unknown opcodes)
module imm_gen
  import shrv32_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (opclass_of(instr[6:0]))
      OC_JALR, OC_LOAD, OC_OPIMM:
        imm = {{20{instr[31]}}, instr[31:20]};
      OC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OC_LUI, OC_AUIPC:
        imm = {instr[31:12], 12'b0};
      OC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with RAW scoreboard
// Ports:
//   RST, CLK_DC                  async active-low reset, decode clock
//   INSTR, PC_IN, IN_VALID       instruction from fetch; IN_READY = accepted this edge
//   A1, A2                       register-file read addresses (combinational)
//   OUT_VALID, OUT_READY         held decoded entry / execute takes it this edge
//   A3, WE, IMM, OPCLASS, FUNCT  decoded fields of the held entry
//   PC_OUT, ILLEGAL              PC of held entry, unknown-opcode flag
//   WB_DONE, WB_A3               one pending write retired or killed
//   FLUSH                        drop held entry, accept nothing
//   STALL_CNT                    saturating count of hazard-stall edges
module decode_stage
  import shrv32_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   RST,
  input  logic                   CLK_DC,
  input  logic [31:0]            INSTR,
  input  logic [31:0]            PC_IN,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic [4:0]             A1,
  output logic [4:0]             A2,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [4:0]             A3,
  output logic                   WE,
  output logic [31:0]            IMM,
  output logic [3:0]             OPCLASS,
  output logic [3:0]             FUNCT,
  output logic [31:0]            PC_OUT,
  output logic                   ILLEGAL,
  input  logic                   WB_DONE,
  input  logic [4:0]             WB_A3,
  input  logic                   FLUSH,
  output logic [STALL_CNT_W-1:0] STALL_CNT
);

  logic [4:0]  rs1, rs2, rd;
  logic [4:0]  held_rs1, held_rs2;
  logic [31:0] busy, busy_nxt;
  logic [31:0] imm;
  opclass_t    cls;
  logic        uses_rs1, uses_rs2, writes_rd;
  logic        pend1, pend2, hazard, accept, handoff;

  assign rs1 = INSTR[19:15];
  assign rs2 = INSTR[24:20];
  assign rd  = INSTR[11:7];
  assign cls = opclass_of(INSTR[6:0]);

  imm_gen u_imm_gen (
    .instr (INSTR),
    .imm   (imm)
  );

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (cls)
      OC_LUI, OC_AUIPC, OC_JAL: writes_rd = 1'b1;
      OC_JALR, OC_LOAD, OC_OPIMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OC_BRANCH, OC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  // The held entry counts as pending too: it has not reached the
  // scoreboard yet, even if execute takes it on this very edge.
  assign pend1 = (rs1 != 5'd0) && (rs1 != 5'd31) &&
                 (busy[rs1] || (OUT_VALID && WE && (A3 == rs1)));
  assign pend2 = (rs2 != 5'd0) && (rs2 != 5'd31) &&
                 (busy[rs2] || (OUT_VALID && WE && (A3 == rs2)));

  assign hazard   = IN_VALID && ((uses_rs1 && pend1) || (uses_rs2 && pend2));
  assign IN_READY = (!OUT_VALID || OUT_READY) && !hazard && !FLUSH;
  assign accept   = IN_VALID && IN_READY;
  assign handoff  = OUT_VALID && OUT_READY && WE && !FLUSH;

  // The register file samples on the same edge, so its data lines up with
  // whatever entry this stage holds after the edge.
  assign A1 = accept ? rs1 : held_rs1;
  assign A2 = accept ? rs2 : held_rs2;

  // Clear first, then set: a same-address clear belongs to an older write.
  always_comb begin
    busy_nxt = busy;
    if (WB_DONE) busy_nxt[WB_A3] = 1'b0;
    if (handoff) busy_nxt[A3] = 1'b1;
  end

  always_ff @(posedge CLK_DC or negedge RST) begin
    if (!RST) begin
      OUT_VALID <= 1'b0;
      A3        <= '0;
      WE        <= 1'b0;
      IMM       <= '0;
      OPCLASS   <= OC_NOP;
      FUNCT     <= '0;
      PC_OUT    <= '0;
      ILLEGAL   <= 1'b0;
      held_rs1  <= '0;
      held_rs2  <= '0;
      busy      <= '0;
      STALL_CNT <= '0;
    end else begin
      busy <= busy_nxt;
      if (accept) begin
        OUT_VALID <= 1'b1;
        A3        <= rd;
        WE        <= writes_rd && (rd != 5'd0) && (rd != 5'd31);
        IMM       <= imm;
        OPCLASS   <= cls;
        FUNCT     <= {INSTR[30], INSTR[14:12]};
        PC_OUT    <= PC_IN;
        ILLEGAL   <= (cls == OC_NOP);
        held_rs1  <= rs1;
        held_rs2  <= rs2;
      end else if (OUT_READY || FLUSH) begin
        OUT_VALID <= 1'b0;
      end
      if (hazard && (STALL_CNT != '1)) STALL_CNT <= STALL_CNT + 1'b1;
    end
  end

endmodule
